// File: rtl/poke_pkg.sv
// Shared scene-sequencing types and frame geometry for the XVGA pipeline.
package poke_pkg;

  // Scene sequencer states: two steady scenes with a fade-out/black/fade-in
  // bridge between them.
  typedef enum logic [2:0] {
    ST_OW       = 3'd0,
    ST_FADE_OUT = 3'd1,
    ST_BLACK    = 3'd2,
    ST_FADE_IN  = 3'd3,
    ST_BAT      = 3'd4
  } scene_state_t;

  // Brightest fade level; a level of FADE_MAX passes pixels through unchanged.
  localparam logic [3:0] FADE_MAX = 4'd15;

  // 1024x768 XVGA frame geometry at 65 MHz.
  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  localparam int H_TOTAL  = 1344;
  localparam int V_TOTAL  = 806;

endpackage

// File: rtl/fade_scaler.sv
// Combinational brightness scaler: each 4-bit channel is multiplied by
// (level+1)/16, so level 15 is pass-through and level 0 is black.
module fade_scaler
  import poke_pkg::*;
(
  input  logic [11:0] pix_in,
  input  logic [3:0]  level_in,
  output logic [11:0] pix_out
);

  // Scale one channel; the product fits 8 bits (15*16 = 240) and the
  // upper nibble is the truncated result.
  function automatic logic [3:0] scale_chan(input logic [3:0] chan,
                                            input logic [3:0] level);
    logic [4:0] gain;
    logic [7:0] prod;
    gain = {1'b0, level} + 5'd1;
    prod = {4'd0, chan} * {3'd0, gain};
    return 4'(prod >> 4);
  endfunction

  assign pix_out = {scale_chan(pix_in[11:8], level_in),
                    scale_chan(pix_in[7:4],  level_in),
                    scale_chan(pix_in[3:0],  level_in)};

endmodule

// File: rtl/scene_sequencer.sv
// Scene sequencer: switches the display between overworld and battle scenes
// with a frame-paced fade through black, gates the scene engines' run-enables
// and produces a one-cycle registered pixel/sync stream.
module scene_sequencer
  import poke_pkg::*;
#(
  parameter int FADE_FRAMES = 2
)
(
  input  logic        vclk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic        battle_req_in,
  input  logic        run_req_in,
  input  logic [11:0] over_pixel_in,
  input  logic [11:0] battle_pixel_in,
  output logic        start_over_out,
  output logic        start_battle_out,
  output logic        mode_out,
  output logic        busy_out,
  output logic        phsync_out,
  output logic        pvsync_out,
  output logic        pblank_out,
  output logic [11:0] pixel_out
);

  // Last value of the per-step frame counter before it wraps and a step occurs.
  localparam logic [3:0] FRAME_LAST = 4'(FADE_FRAMES - 1);

  scene_state_t r_state;
  logic [3:0]   r_level;
  logic [3:0]   r_count;
  logic         r_pending;
  logic         r_mode;
  logic         r_start_over;
  logic         r_start_battle;
  logic         r_busy;

  logic         r_hsync_p1;
  logic         r_vsync_p1;
  logic         r_blank_p1;
  logic [11:0]  r_pixel_p1;

  logic         w_strobe;
  logic         w_req_valid;
  logic         w_step;
  logic [11:0]  w_src_pixel;
  logic [11:0]  w_scaled_pixel;

  // Frame strobe: first pixel of the frame, the only cycle state may move.
  assign w_strobe = (hcount_in == 11'd0) && (vcount_in == 10'd0);

  // Only the request that makes sense for the current steady scene is heard;
  // when both arrive together the other one is simply ignored.
  assign w_req_valid = (r_state == ST_OW)  ? battle_req_in :
                       (r_state == ST_BAT) ? run_req_in    : 1'b0;

  assign w_step = (r_count == FRAME_LAST);

  assign w_src_pixel = r_mode ? battle_pixel_in : over_pixel_in;

  fade_scaler u_fade_scaler (
    .pix_in   (w_src_pixel),
    .level_in (r_level),
    .pix_out  (w_scaled_pixel)
  );

  // Scene FSM: request capture, frame-paced fade stepping and run-enables.
  always_ff @(posedge vclk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state        <= ST_OW;
      r_level        <= FADE_MAX;
      r_count        <= 4'd0;
      r_pending      <= 1'b0;
      r_mode         <= 1'b0;
      r_start_over   <= 1'b1;
      r_start_battle <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      // A single sticky flag: extra pulses before the strobe change nothing.
      if (w_req_valid) begin
        r_pending <= 1'b1;
      end

      if (w_strobe) begin
        case (r_state)
          ST_OW, ST_BAT: begin
            if (r_pending) begin
              // Later assignment wins over a same-cycle request capture.
              r_pending      <= 1'b0;
              r_state        <= ST_FADE_OUT;
              r_count        <= 4'd0;
              r_level        <= FADE_MAX;
              r_start_over   <= 1'b0;
              r_start_battle <= 1'b0;
              r_busy         <= 1'b1;
            end
          end

          ST_FADE_OUT: begin
            if (w_step) begin
              r_count <= 4'd0;
              if (r_level == 4'd0) begin
                r_state <= ST_BLACK;
              end else begin
                r_level <= r_level - 4'd1;
              end
            end else begin
              r_count <= r_count + 4'd1;
            end
          end

          ST_BLACK: begin
            // Swap scenes while the screen is fully dark and wake the new engine.
            r_mode         <= ~r_mode;
            r_start_over   <= r_mode;
            r_start_battle <= ~r_mode;
            r_state        <= ST_FADE_IN;
            r_level        <= 4'd0;
            r_count        <= 4'd0;
          end

          ST_FADE_IN: begin
            if (w_step) begin
              r_count <= 4'd0;
              if (r_level == FADE_MAX) begin
                r_state <= r_mode ? ST_BAT : ST_OW;
                r_busy  <= 1'b0;
              end else begin
                r_level <= r_level + 4'd1;
              end
            end else begin
              r_count <= r_count + 4'd1;
            end
          end

          default: begin
            r_state <= ST_OW;
            r_level <= FADE_MAX;
            r_count <= 4'd0;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---- stage p1: registered pixel and syncs, all one cycle behind inputs ----
  // Output pipeline: scaled (or blanked) pixel travels with its sync bits.
  always_ff @(posedge vclk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hsync_p1 <= 1'b0;
      r_vsync_p1 <= 1'b0;
      r_blank_p1 <= 1'b0;
      r_pixel_p1 <= 12'h000;
    end else begin
      r_hsync_p1 <= hsync_in;
      r_vsync_p1 <= vsync_in;
      r_blank_p1 <= blank_in;
      r_pixel_p1 <= blank_in ? 12'h000 : w_scaled_pixel;
    end
  end

  assign start_over_out   = r_start_over;
  assign start_battle_out = r_start_battle;
  assign mode_out         = r_mode;
  assign busy_out         = r_busy;
  assign phsync_out       = r_hsync_p1;
  assign pvsync_out       = r_vsync_p1;
  assign pblank_out       = r_blank_p1;
  assign pixel_out        = r_pixel_p1;

endmodule

// File: tb/tb_scene_sequencer.sv
// Bench for scene_sequencer: a shrunken 16x4 frame drives the strobe, a
// frame-count model predicts every output each cycle, and literal checks pin
// key points of the fade timeline.
module tb_scene_sequencer;

  localparam int FF       = 1;
  localparam int HT       = 16;
  localparam int VT       = 4;
  localparam int WAIT_MAX = 4000;

  logic        vclk  = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hc    = 11'd0;
  logic [9:0]  vc    = 10'd0;
  logic        hsync, vsync, blank;
  logic        breq  = 1'b0;
  logic        rreq  = 1'b0;
  logic [11:0] opix, bpix;

  logic        start_over_out, start_battle_out, mode_out, busy_out;
  logic        phsync_out, pvsync_out, pblank_out;
  logic [11:0] pixel_out;

  int fr      = 0;
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: scene, pending flag, transition in progress, strobes since start.
  bit          m_mode, m_pend, m_act, m_strobe;
  int          m_fs;
  logic [11:0] e_pix;
  logic        e_hs, e_vs, e_bl;

  always #5 vclk = ~vclk;

  assign hsync = hc[0];
  assign vsync = (vc == 10'd1);
  assign blank = (hc >= 11'd12) || (vc == 10'd3);
  assign opix  = (hc == 11'd5 || hc == 11'd13) ? 12'hF84 :
                 {hc[3:0], 2'b10, vc[1:0], hc[3:0] ^ 4'hC};
  assign bpix  = (hc == 11'd5) ? 12'h5A3 : {~hc[3:0], 4'h6, hc[3:0]};

  scene_sequencer #(.FADE_FRAMES(FF)) dut (
    .vclk_in          (vclk),
    .rst_n_in         (rst_n),
    .hcount_in        (hc),
    .vcount_in        (vc),
    .hsync_in         (hsync),
    .vsync_in         (vsync),
    .blank_in         (blank),
    .battle_req_in    (breq),
    .run_req_in       (rreq),
    .over_pixel_in    (opix),
    .battle_pixel_in  (bpix),
    .start_over_out   (start_over_out),
    .start_battle_out (start_battle_out),
    .mode_out         (mode_out),
    .busy_out         (busy_out),
    .phsync_out       (phsync_out),
    .pvsync_out       (pvsync_out),
    .pblank_out       (pblank_out),
    .pixel_out        (pixel_out)
  );

  // Frame timing generator.
  initial forever begin
    @(posedge vclk);
    #1;
    if (hc == 11'(HT - 1)) begin
      hc = 11'd0;
      if (vc == 10'(VT - 1)) begin
        vc = 10'd0;
        fr = fr + 1;
      end else begin
        vc = vc + 10'd1;
      end
    end else begin
      hc = hc + 11'd1;
    end
  end

  // Brightness level implied by how many strobes have passed since the fade began.
  function automatic int m_level();
    if (!m_act)              return 15;
    if (m_fs < 16 * FF)      return 15 - m_fs / FF;
    if (m_fs == 16 * FF)     return 0;
    return (m_fs - 16 * FF - 1) / FF;
  endfunction

  function automatic logic [11:0] scale_px(input logic [11:0] p, input int l);
    logic [3:0] r, g, b;
    r = 4'((int'(p[11:8]) * (l + 1)) / 16);
    g = 4'((int'(p[7:4])  * (l + 1)) / 16);
    b = 4'((int'(p[3:0])  * (l + 1)) / 16);
    return {r, g, b};
  endfunction

  // Behavioural model, advanced once per clock edge.
  initial forever begin
    @(posedge vclk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 1'b0; m_pend = 1'b0; m_act = 1'b0; m_fs = 0;
      e_pix = 12'h000; e_hs = 1'b0; e_vs = 1'b0; e_bl = 1'b0;
    end else begin
      e_hs = hsync; e_vs = vsync; e_bl = blank;
      e_pix = blank ? 12'h000 : scale_px(m_mode ? bpix : opix, m_level());
      m_strobe = (hc == 11'd0) && (vc == 10'd0);
      if (!m_act) begin
        if (m_strobe && m_pend) begin
          m_act = 1'b1; m_fs = 0; m_pend = 1'b0;
        end else if (m_mode ? rreq : breq) begin
          m_pend = 1'b1;
        end
      end else if (m_strobe) begin
        m_fs = m_fs + 1;
        if (m_fs == 16 * FF + 1) m_mode = !m_mode;
        if (m_fs == 32 * FF + 1) m_act = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge vclk);
    if (chk_en) begin
      logic [18:0] act, exp;
      bit front;
      front = m_act && (m_fs <= 16 * FF);
      act = {mode_out, busy_out, start_over_out, start_battle_out,
             phsync_out, pvsync_out, pblank_out, pixel_out};
      exp = {m_mode, m_act, !front && !m_mode, !front && m_mode,
             e_hs, e_vs, e_bl, e_pix};
      n_tests = n_tests + 1;
      if (act !== exp) begin
        n_fail = n_fail + 1;
        $display("FAIL model_cycle t=%0t frame=%0d h=%0d got=%h want=%h (mode,busy,so,sb,hs,vs,bl,pix12)",
                 $time, fr, hc, act, exp);
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic chk12(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Advance on negedges until the given frame/line/pixel is being presented.
  task automatic wait_at(input int f, input int v, input int h);
    int n;
    n = 0;
    while (!(fr == f && vc == 10'(v) && hc == 11'(h)) && n < WAIT_MAX) begin
      @(negedge vclk);
      n = n + 1;
    end
    if (n >= WAIT_MAX) begin
      n_tests = n_tests + 1;
      n_fail  = n_fail + 1;
      $display("FAIL wait_timeout got=frame%0d want=frame%0d", fr, f);
    end
  endtask

  task automatic pulse_breq();
    breq = 1'b1;
    @(negedge vclk);
    breq = 1'b0;
  endtask

  // Output at the next negedge reflects the pixel presented at this one.
  task automatic chk_pix_at(input string name, input int f, input logic [11:0] exp);
    wait_at(f, 1, 5);
    @(negedge vclk);
    chk12(name, pixel_out, exp);
  endtask

  int a0, b0, c0, d0;

  initial begin
    repeat (3) @(negedge vclk);
    chk1 ("rst_mode",      mode_out,         1'b0);
    chk1 ("rst_start_ow",  start_over_out,   1'b1);
    chk1 ("rst_start_bat", start_battle_out, 1'b0);
    chk1 ("rst_busy",      busy_out,         1'b0);
    chk1 ("rst_phsync",    phsync_out,       1'b0);
    chk12("rst_pixel",     pixel_out,        12'h000);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Overworld -> battle, single request.
    a0 = fr + 1;
    wait_at(a0, 1, 3);
    pulse_breq();
    wait_at(a0 + 1, 0, 2);
    chk1 ("a_fadeout_busy",     busy_out,       1'b1);
    chk1 ("a_fadeout_start_ow", start_over_out, 1'b0);
    chk_pix_at("a_level14", a0 + 2, 12'hE73);
    chk_pix_at("a_level7",  a0 + 9, 12'h742);
    wait_at(a0 + 9, 1, 13);
    @(negedge vclk);
    chk12("a_level7_blank", pixel_out, 12'h000);
    chk_pix_at("a_level0", a0 + 16, 12'h000);
    wait_at(a0 + 17, 0, 2);
    chk1 ("a_black_busy", busy_out, 1'b1);
    chk1 ("a_black_mode", mode_out, 1'b0);
    wait_at(a0 + 18, 0, 2);
    chk1 ("a_fadein_mode",      mode_out,         1'b1);
    chk1 ("a_fadein_start_bat", start_battle_out, 1'b1);
    chk_pix_at("a_level15_bat", a0 + 33, 12'h5A3);
    wait_at(a0 + 34, 0, 2);
    chk1 ("a_bat_busy", busy_out, 1'b0);
    chk1 ("a_bat_mode", mode_out, 1'b1);

    // In battle, run and battle requests on the same cycle.
    b0 = a0 + 35;
    wait_at(b0, 1, 3);
    rreq = 1'b1;
    breq = 1'b1;
    @(negedge vclk);
    rreq = 1'b0;
    breq = 1'b0;
    wait_at(b0 + 1, 0, 2);
    chk1 ("b_fadeout_busy", busy_out, 1'b1);
    wait_at(b0 + 18, 0, 2);
    chk1 ("b_back_mode",     mode_out,       1'b0);
    chk1 ("b_back_start_ow", start_over_out, 1'b1);
    wait_at(b0 + 36, 0, 2);
    chk1 ("b_idle_after", busy_out, 1'b0);

    // Three battle requests in one frame give exactly one transition.
    c0 = b0 + 37;
    wait_at(c0, 1, 3);
    pulse_breq();
    wait_at(c0, 1, 6);
    pulse_breq();
    wait_at(c0, 1, 9);
    pulse_breq();
    wait_at(c0 + 1, 0, 2);
    chk1 ("c_fadeout_busy", busy_out, 1'b1);
    wait_at(c0 + 34, 0, 2);
    chk1 ("c_bat_mode", mode_out, 1'b1);
    wait_at(c0 + 36, 0, 2);
    chk1 ("c_no_second_fade", busy_out, 1'b0);

    // Return to overworld, then reset in the middle of the fade-in.
    d0 = c0 + 37;
    wait_at(d0, 1, 3);
    rreq = 1'b1;
    @(negedge vclk);
    rreq = 1'b0;
    chk_pix_at("d_level5_ow", d0 + 23, 12'h531);
    wait_at(d0 + 23, 1, 8);
    rst_n = 1'b0;
    #1;
    chk1 ("d_rst_mode",     mode_out,       1'b0);
    chk1 ("d_rst_start_ow", start_over_out, 1'b1);
    chk1 ("d_rst_busy",     busy_out,       1'b0);
    chk12("d_rst_pixel",    pixel_out,      12'h000);
    @(negedge vclk);
    @(negedge vclk);
    rst_n = 1'b1;
    chk_pix_at("d_after_rst_pass", d0 + 24, 12'hF84);
    wait_at(d0 + 25, 0, 2);
    chk1 ("d_after_rst_idle", busy_out, 1'b0);

    repeat (3) @(negedge vclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scene_sequencer.md
SCENE_SEQUENCER -- requirements
Module: scene_sequencer

Interface
REQ-001 SHALL have parameter FADE_FRAMES, default 2: frames per fade-level step (legal 1..15).
REQ-002 SHALL have port vclk_in, input, 1: 65 MHz pixel clock, the only clock.
REQ-003 SHALL have port rst_n_in, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port hcount_in, input, 11: horizontal pixel index (0..1023).
REQ-005 SHALL have port vcount_in, input, 10: vertical pixel index (0..767).
REQ-006 SHALL have ports hsync_in / vsync_in / blank_in, input, 1 each: XVGA timing; blank_in=1 means black.
REQ-007 SHALL have port battle_req_in, input, 1: pulse from the overworld controller requesting battle entry.
REQ-008 SHALL have port run_req_in, input, 1: pulse from the battle engine requesting overworld return.
REQ-009 SHALL have ports over_pixel_in / battle_pixel_in, input, 12 each: scene pixels, r=11:8, g=7:4, b=3:0.
REQ-010 SHALL have ports start_over_out / start_battle_out, output, 1 each: run-enable levels to the scene engines.
REQ-011 SHALL have port mode_out, output, 1: displayed scene, 0=overworld, 1=battle.
REQ-012 SHALL have port busy_out, output, 1: high in any fade or black state.
REQ-013 SHALL have ports phsync_out / pvsync_out / pblank_out, output, 1 each; pixel_out, output, 12.

Function
REQ-014 SHALL define frame strobe as hcount_in==0 && vcount_in==0; state, level and mode change only on a strobe cycle.
REQ-015 SHALL use states OW, FADE_OUT, BLACK, FADE_IN, BAT.
REQ-016 SHALL latch battle_req_in into a sticky pending flag only in OW, and run_req_in only in BAT; requests in any other state are dropped.
REQ-017 SHALL move OW/BAT -> FADE_OUT on the first strobe with pending set, clearing pending and the frame counter, keeping level=15.
REQ-018 SHALL deassert both start_*_out on entry to FADE_OUT.
REQ-019 SHALL, in FADE_OUT/FADE_IN, increment a frame counter per strobe; when counter==FADE_FRAMES-1 it wraps to 0 and a step occurs.
REQ-020 SHALL, on a FADE_OUT step, go to BLACK if level==0, else decrement level.
REQ-021 SHALL, on the strobe in BLACK, toggle mode_out, assert the new scene's start_*_out, and enter FADE_IN with level=0.
REQ-022 SHALL, on a FADE_IN step, go to OW or BAT (per mode_out) if level==15, else increment level.
REQ-023 SHALL select the source pixel by mode_out and scale each 4-bit channel as (c*(level+1))>>4; level 15 is pass-through and level 0 is black.
REQ-024 SHALL output pixel_out=0 when blank_in=1.
REQ-025 SHALL register pixel_out, phsync_out, pvsync_out and pblank_out, with exactly 1 cycle latency from inputs, all aligned.
REQ-026 SHALL give priority to the request valid for the current state when battle_req_in and run_req_in arrive together; the other is dropped.
REQ-027 SHALL keep at most one pending request; further pulses before the strobe have no effect.

Reset
REQ-028 SHALL, while rst_n_in=0, force state=OW, mode_out=0, level=15, counter=0, pending=0, start_over_out=1, start_battle_out=0, busy_out=0, pixel_out=0, and all sync outputs=0.
REQ-029 SHALL abort any fade on reset mid-operation, with no partial-level residue after release.

Structure
REQ-030 SHALL take scene_state_t (enum), FADE_MAX=15, and the frame dimension constants from shared package poke_pkg.
REQ-031 SHALL instantiate one combinational sub-module fade_scaler (12-bit pixel, 4-bit level in -> 12-bit pixel out).
REQ-032 SHALL hold the state machine, counter and output registers in scene_sequencer only.

Verification
REQ-033 SHALL cover, with FADE_FRAMES=1, battle_req pulse in frame 0: FADE_OUT at strobe of frame 1, level 14 at frame 2, level 0 at frame 16, BLACK at frame 17, mode_out=1 and start_battle_out=1 at frame 18, level 15 at frame 33, BAT with busy_out=0 at frame 34.
REQ-034 SHALL cover, in BAT, run_req and battle_req pulsed on the same cycle: return to overworld starts, and the battle_req has no effect.
REQ-035 SHALL cover over_pixel_in=12'hF84 at level 7 -> pixel_out=12'h742; with blank_in=1 -> 12'h000.
REQ-036 SHALL cover rst_n_in low in FADE_IN at level 5: immediately mode_out=0, start_over_out=1, pixel_out=0; after release, pass-through at level 15.
REQ-037 SHALL cover three battle_req pulses within one frame: exactly one transition and no second fade afterward.
REQ-038 SHALL cover hsync_in toggling: phsync_out follows with exactly 1 cycle delay in every state.
